// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; define MEM_LOAD_FWD_EN to forward the arriving load to ID.
`ifndef EXE_TO_MEM_WD
`define EXE_TO_MEM_WD 78
`endif
`ifndef MEM_TO_WB_WD
`define MEM_TO_WB_WD 78
`endif
`ifndef MEM_TO_ID_WD
`define MEM_TO_ID_WD 41
`endif

module mem_stage #(
  parameter int DROP_CNT_W = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      exe_to_mem_valid,
  input  logic                      exe_req_ok,
  input  logic [`EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
  output logic                      mem_allowin,
  input  logic                      wb_allowin,
  output logic                      mem_to_wb_valid,
  output logic [`MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
  output logic [`MEM_TO_ID_WD-1:0]  mem_to_id_bus,
  output logic                      mem_to_exe_flush_excp_ertn,
  input  logic                      wb_flush,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata
);
  localparam logic [DROP_CNT_W:0] CNT_MAX = {1'b0, {DROP_CNT_W{1'b1}}};
  logic                      mem_valid, wait_data, buf_valid;
  logic [31:0]               buf_data;
  logic [DROP_CNT_W-1:0]     drop_cnt;
  logic [`EXE_TO_MEM_WD-1:0] bus_r;
  logic                      regw, res_from_mem, load_sign, excp, ertn, exist_csrr;
  logic [4:0]                regw_addr;
  logic [31:0]               result, raw, ext, final_data, fwd_data;
  logic [1:0]                mem_ins;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic                      owned_ok, ready_go, leave, block;
  logic [DROP_CNT_W:0]       inc, dec, cnt_sum;
  assign regw         = bus_r[76];
  assign regw_addr    = bus_r[75:71];
  assign res_from_mem = bus_r[70];
  assign result       = bus_r[69:38];
  assign mem_ins      = bus_r[37:36];
  assign load_sign    = bus_r[35];
  assign excp         = bus_r[34];
  assign ertn         = bus_r[33];
  assign exist_csrr   = bus_r[32];
  // Responses are ours only once every response owed to flushed requests has drained.
  assign owned_ok   = data_sram_data_ok & (drop_cnt == '0);
  assign ready_go   = ~wait_data | buf_valid | owned_ok | excp | ertn;
  assign leave      = mem_valid & ready_go & wb_allowin;
  assign mem_allowin     = ~mem_valid | ready_go & wb_allowin;
  assign mem_to_wb_valid = mem_valid & ready_go;
  assign mem_to_exe_flush_excp_ertn = mem_valid & (excp | ertn) | wb_flush;
  assign raw    = buf_valid ? buf_data : data_sram_rdata;
  assign byte_v = result[1] ? (result[0] ? raw[31:24] : raw[23:16])
                            : (result[0] ? raw[15:8]  : raw[7:0]);
  assign half_v = result[1] ? raw[31:16] : raw[15:0];
  assign ext    = mem_ins == 2'b01 ? {{24{load_sign & byte_v[7]}}, byte_v}
                : mem_ins == 2'b10 ? {{16{load_sign & half_v[15]}}, half_v}
                : raw;
  assign final_data = res_from_mem ? ext : result;
`ifdef MEM_LOAD_FWD_EN
  assign block    = mem_valid & res_from_mem & wait_data & ~owned_ok;
  assign fwd_data = final_data;
`else
  assign block    = mem_valid & res_from_mem;
  assign fwd_data = result;
`endif
  assign mem_to_wb_bus = {bus_r[77:70], final_data, bus_r[37:0]};
  assign mem_to_id_bus = {mem_valid, block, regw & ~excp, regw_addr, fwd_data, exist_csrr};
  assign inc     = (DROP_CNT_W+1)'(wb_flush & wait_data & ~owned_ok)
                 + (DROP_CNT_W+1)'(wb_flush & exe_req_ok);
  assign dec     = (DROP_CNT_W+1)'(data_sram_data_ok & (drop_cnt != '0));
  assign cnt_sum = {1'b0, drop_cnt} + inc - dec;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      wait_data <= 1'b0;
      buf_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= cnt_sum > CNT_MAX ? CNT_MAX[DROP_CNT_W-1:0] : cnt_sum[DROP_CNT_W-1:0];
      if (wb_flush) mem_valid <= 1'b0;
      else if (mem_allowin) mem_valid <= exe_to_mem_valid;
      if (wb_flush) wait_data <= 1'b0;
      else if (mem_allowin & exe_to_mem_valid) wait_data <= exe_req_ok;
      else if (owned_ok) wait_data <= 1'b0;
      if (wb_flush | leave) buf_valid <= 1'b0;
      else if (owned_ok & wait_data & mem_valid) buf_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_allowin & exe_to_mem_valid) bus_r <= exe_to_mem_bus;
    if (owned_ok & wait_data & mem_valid & ~buf_valid) buf_data <= data_sram_rdata;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors and multi-cycle sequences for mem_stage.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_to_mem_valid, exe_req_ok, wb_allowin, wb_flush;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [77:0] exe_to_mem_bus;
  logic        mem_allowin, mem_to_wb_valid, mem_to_exe_flush_excp_ertn;
  logic [77:0] mem_to_wb_bus;
  logic [40:0] mem_to_id_bus;
  int          vec_cnt = 0;
  int          miscompares = 0;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_req_ok(exe_req_ok),
    .exe_to_mem_bus(exe_to_mem_bus), .mem_allowin(mem_allowin),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_id_bus(mem_to_id_bus),
    .mem_to_exe_flush_excp_ertn(mem_to_exe_flush_excp_ertn),
    .wb_flush(wb_flush), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ins;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [77:0] mk(input logic rfm, input logic [31:0] res,
                                     input logic [1:0] ins, input logic sgn,
                                     input logic ex, input logic er);
    return {1'b0, 1'b1, 5'd7, rfm, res, ins, sgn, ex, er, 1'b1, 32'h1c00_0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic rq, input logic dk, input logic wa,
                     input logic fl, input logic [31:0] rd, input logic [77:0] b);
    @(negedge clk);
    exe_to_mem_valid = v; exe_req_ok = rq; data_sram_data_ok = dk;
    wb_allowin = wa; wb_flush = fl; data_sram_rdata = rd; exe_to_mem_bus = b;
    #1;
  endtask

  vec_t        vecs[9];
  logic [77:0] b;
  logic        blk_exp;

  initial begin
    vecs[0] = '{2'b01, 1'b1, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1] = '{2'b01, 1'b0, 32'h1003, 32'h80FF_1234, 32'h0000_0080};
    vecs[2] = '{2'b01, 1'b1, 32'h1000, 32'h80FF_1234, 32'h0000_0034};
    vecs[3] = '{2'b01, 1'b1, 32'h1002, 32'h80FF_1234, 32'hFFFF_FFFF};
    vecs[4] = '{2'b01, 1'b0, 32'h1001, 32'h80FF_1234, 32'h0000_0012};
    vecs[5] = '{2'b10, 1'b0, 32'h2002, 32'hBEEF_0000, 32'h0000_BEEF};
    vecs[6] = '{2'b10, 1'b1, 32'h2002, 32'hBEEF_0000, 32'hFFFF_BEEF};
    vecs[7] = '{2'b10, 1'b1, 32'h2000, 32'h1234_7FFE, 32'h0000_7FFE};
    vecs[8] = '{2'b11, 1'b1, 32'h3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
`ifdef MEM_LOAD_FWD_EN
    blk_exp = 1'b0;
`else
    blk_exp = 1'b1;
`endif
    resetn = 1'b0;
    exe_to_mem_valid = 0; exe_req_ok = 0; data_sram_data_ok = 0;
    wb_allowin = 0; wb_flush = 0; data_sram_rdata = 0; exe_to_mem_bus = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", mem_allowin, 1);
    chk("rst_wb_valid", mem_to_wb_valid, 0);
    chk("rst_flush", mem_to_exe_flush_excp_ertn, 0);
    chk("rst_id_valid", mem_to_id_bus[40], 0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      b = mk(1'b1, vecs[i].addr, vecs[i].ins, vecs[i].sgn, 1'b0, 1'b0);
      cyc(1, 1, 0, 1, 0, 0, b);
      chk($sformatf("v%0d_allowin", i), mem_allowin, 1);
      cyc(0, 0, 1, 1, 0, vecs[i].rdata, '0);
      chk($sformatf("v%0d_valid", i), mem_to_wb_valid, 1);
      chk($sformatf("v%0d_data", i), mem_to_wb_bus[69:38], vecs[i].exp);
    end
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("vec_idle_valid", mem_to_wb_valid, 0);

    // ld.b waiting three cycles for its response
    b = mk(1'b1, 32'h1003, 2'b01, 1'b1, 1'b0, 1'b0);
    cyc(1, 1, 0, 1, 0, 0, b);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 32'hAAAA_AAAA, '0);
      chk($sformatf("t1_wait%0d_valid", i), mem_to_wb_valid, 0);
      chk($sformatf("t1_wait%0d_block", i), mem_to_id_bus[39], 1);
    end
    cyc(0, 0, 1, 1, 0, 32'h80FF_1234, '0);
    chk("t1_valid", mem_to_wb_valid, 1);
    chk("t1_data", mem_to_wb_bus[69:38], 32'hFFFF_FF80);
    chk("t1_block", mem_to_id_bus[39], blk_exp);
    chk("t1_fwd", mem_to_id_bus[32:1], blk_exp ? 32'h1003 : 32'hFFFF_FF80);
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("t1_gone", mem_to_id_bus[40], 0);

    // ld.hu buffered while WB stalls
    b = mk(1'b1, 32'h2002, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 1, 0, 0, 32'hBEEF_0000, '0);
    chk("t2_ok_valid", mem_to_wb_valid, 1);
    chk("t2_ok_allowin", mem_allowin, 0);
    chk("t2_ok_data", mem_to_wb_bus[69:38], 32'h0000_BEEF);
    cyc(0, 0, 0, 0, 0, 32'h1234_5678, '0);
    chk("t2_buf_valid", mem_to_wb_valid, 1);
    chk("t2_buf_data", mem_to_wb_bus[69:38], 32'h0000_BEEF);
    chk("t2_buf_allowin", mem_allowin, 0);
    chk("t2_buf_block", mem_to_id_bus[39], blk_exp);
    cyc(0, 0, 0, 1, 0, 32'h1234_5678, '0);
    chk("t2_go_valid", mem_to_wb_valid, 1);
    chk("t2_go_data", mem_to_wb_bus[69:38], 32'h0000_BEEF);
    chk("t2_go_allowin", mem_allowin, 1);
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("t2_no_dup", mem_to_wb_valid, 0);

    // flush while waiting: first response afterwards is stale
    b = mk(1'b1, 32'h4000, 2'b11, 1'b0, 1'b0, 1'b0);
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 0, 1, 1, 0, '0);
    chk("t3_flush", mem_to_exe_flush_excp_ertn, 1);
    cyc(1, 1, 0, 1, 0, 0, b);
    chk("t3_allowin", mem_allowin, 1);
    chk("t3_empty", mem_to_wb_valid, 0);
    cyc(0, 0, 1, 1, 0, 32'h1111_1111, '0);
    chk("t3_stale", mem_to_wb_valid, 0);
    cyc(0, 0, 1, 1, 0, 32'h0000_00AB, '0);
    chk("t3_valid", mem_to_wb_valid, 1);
    chk("t3_data", mem_to_wb_bus[69:38], 32'h0000_00AB);

    // flush with an EXE request in the same cycle owes two responses
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 1, 0, 1, 1, 0, '0);
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 1, 1, 0, 32'h1, '0);
    chk("d2_stale1", mem_to_wb_valid, 0);
    cyc(0, 0, 1, 1, 0, 32'h2, '0);
    chk("d2_stale2", mem_to_wb_valid, 0);
    cyc(0, 0, 1, 1, 0, 32'hCD, '0);
    chk("d2_valid", mem_to_wb_valid, 1);
    chk("d2_data", mem_to_wb_bus[69:38], 32'hCD);

    // response coincident with flush is consumed, nothing owed
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 1, 1, 1, 32'h55, '0);
    chk("sim_flush", mem_to_exe_flush_excp_ertn, 1);
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 1, 1, 0, 32'h66, '0);
    chk("sim_valid", mem_to_wb_valid, 1);
    chk("sim_data", mem_to_wb_bus[69:38], 32'h66);

    // exception and ertn instructions
    cyc(1, 0, 0, 0, 0, 0, mk(1'b0, 32'h9999, 2'b00, 1'b0, 1'b1, 1'b0));
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("t4_flush", mem_to_exe_flush_excp_ertn, 1);
    chk("t4_valid", mem_to_wb_valid, 1);
    chk("t4_regw", mem_to_id_bus[38], 0);
    chk("t4_csrr", mem_to_id_bus[0], 1);
    chk("t4_data", mem_to_wb_bus[69:38], 32'h9999);
    cyc(0, 0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("t4_flush_off", mem_to_exe_flush_excp_ertn, 0);
    cyc(1, 0, 0, 1, 0, 0, mk(1'b0, 32'h8888, 2'b00, 1'b0, 1'b0, 1'b1));
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("ertn_flush", mem_to_exe_flush_excp_ertn, 1);
    chk("ertn_regw", mem_to_id_bus[38], 1);
    chk("ertn_valid", mem_to_wb_valid, 1);

    // async reset mid-wait with a stale response owed
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 0, 1, 1, 0, '0);
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("t5_pre_block", mem_to_id_bus[39], 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_allowin", mem_allowin, 1);
    chk("t5_valid", mem_to_wb_valid, 0);
    chk("t5_id_valid", mem_to_id_bus[40], 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1, 1, 0, 1, 0, 0, b);
    cyc(0, 0, 1, 1, 0, 32'h77, '0);
    chk("t5_after_valid", mem_to_wb_valid, 1);
    chk("t5_after_data", mem_to_wb_bus[69:38], 32'h77);
    cyc(0, 0, 0, 1, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
